// File: rtl/sign_restore_pkg.sv
// sign_restore shared types: FSM state enum and signed range helpers.
// Helpers return 64-bit values; callers truncate to their own width N.
package sign_restore_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic [63:0] smax(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  // Bit pattern of -2^(n-1); also the largest negatable magnitude.
  function automatic logic [63:0] smin(input int n);
    return 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/sign_restore_negator.sv
// bit_serial_negator: LSB-first two's-complement negation cell.
// Copies bits until the first one, then inverts the rest when sign is set.
module bit_serial_negator (
  input  logic clk,
  input  logic rst_n,
  input  logic b,
  input  logic sign,
  input  logic clear,
  input  logic enable,
  output logic out_bit
);

  logic r_seen_one;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seen_one <= 1'b0;
    end else if (clear) begin
      r_seen_one <= 1'b0;
    end else if (enable) begin
      r_seen_one <= r_seen_one | b;
    end
  end

  assign out_bit = (sign && r_seen_one) ? ~b : b;

endmodule

// File: rtl/sign_restore.sv
// sign_restore: bit-serial magnitude+sign to two's-complement rebuild.
// Build option SIGN_RESTORE_SATURATE_EN clamps out-of-range results.
module sign_restore
  import sign_restore_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] magnitude,
  input  logic         sign,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         range_err
);

  localparam int CNT_W = (N > 2) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
  localparam logic [N-1:0] MAX_POS = N'(smax(N));
  localparam logic [N-1:0] MIN_NEG = N'(smin(N));

  state_t         r_state;
  logic [N-1:0]   r_shift;
  logic [N-1:0]   r_res;
  logic [CNT_W-1:0] r_cnt;
  logic           r_sign;
  logic           r_err;

  logic w_accept;
  logic w_shift;
  logic w_out_bit;
  logic w_err;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_shift   = (r_state == S_SHIFT);

  // Negative side reaches one step further than positive side.
  assign w_err = sign ? (magnitude > MIN_NEG)
                      : (magnitude >= MIN_NEG);

  bit_serial_negator u_neg (
    .clk     (clk),
    .rst_n   (rst_n),
    .b       (r_shift[0]),
    .sign    (r_sign),
    .clear   (w_accept),
    .enable  (w_shift),
    .out_bit (w_out_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_sign  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shift <= magnitude;
            r_sign  <= sign;
            r_err   <= w_err;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_shift <= r_shift >> 1;
          r_res   <= {w_out_bit, r_res[N-1:1]};
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign range_err = r_err;

`ifdef SIGN_RESTORE_SATURATE_EN
  logic [N-1:0] w_sat;
  assign w_sat  = r_sign ? MIN_NEG : MAX_POS;
  assign result = r_err ? w_sat : r_res;
`else
  assign result = r_res;
`endif

endmodule

// File: doc/sign_restore.md
# sign_restore

Sequential inverse of the absolute-value unit: takes an unsigned magnitude and a sign bit and rebuilds the N-bit two's-complement value. Computes bit-serially, LSB first, using the copy-until-first-one-then-invert negation rule, one bit per clock. Sits after the magnitude datapath, at the register-file write port. Uses valid/ready handshakes on input and output and flags magnitudes that cannot be represented.

## Interface
Parameters:
- N, 8, data width in bits (N ≥ 2); magnitude and result are both N bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  magnitude/sign present.
- in_ready  output  1  block can accept an operand (high only in IDLE).
- magnitude  input  N  unsigned magnitude |x|.
- sign  input  1  1 = negative result requested.
- out_valid  output  1  result/range_err valid.
- out_ready  input  1  consumer accepts the result.
- result  output  N  signed two's-complement value.
- range_err  output  1  magnitude not representable with the requested sign.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, perform these actions, then go to SHIFT:
  - load magnitude into the shift register;
  - latch sign;
  - clear seen_one and bit counter;
  - register range_err.
- Range rule, evaluated at accept:
  - sign=0: error if magnitude ≥ 2^(N-1).
  - sign=1: error if magnitude > 2^(N-1).
  - sign=1 with magnitude=0 gives result 0, no error (no negative zero).
- SHIFT, each cycle:
  - b = shift-register LSB;
  - out bit = (sign && seen_one) ? ~b : b;
  - out bit shifts into the result register from the MSB side;
  - seen_one |= b;
  - counter increments.
  - After N bits, go to DONE.
- sign=0 takes the same serial path with the same latency. Latency does not depend on the data.
- DONE: out_valid=1, and result/range_err are held stable. On out_ready, go to IDLE. in_ready=0, so there is no same-cycle re-accept.
- Arithmetic: result equals magnitude or −magnitude, mod 2^N, unless the configuration below overrides it.

## Timing
- Reset: rst_n low at a rising edge forces, on that edge:
  - state=IDLE, in_ready=1;
  - out_valid=0, result=0, range_err=0;
  - internal shift register, counter and seen_one cleared.
- Reset mid-SHIFT or in DONE aborts the operation. The pending result is discarded and never presented.
- Accept at edge k. SHIFT covers edges k+1 … k+N. out_valid is high starting the cycle after edge k+N (latency N cycles from accept).
- Throughput: one operand per N+2 cycles minimum (accept, N shifts, one DONE cycle with out_ready=1).
- Backpressure: out_ready low holds DONE indefinitely, with result and range_err unchanged and in_ready=0.
- in_valid during SHIFT/DONE is ignored. The source must hold its data until in_ready.
- magnitude and sign are sampled only at the accept edge. Later changes have no effect.

## Configuration
- SIGN_RESTORE_SATURATE_EN defined: when range_err=1, result in DONE is forced to the clamped value:
  - 2^(N-1)−1 for sign=0;
  - −2^(N-1) for sign=1.
- SIGN_RESTORE_SATURATE_EN undefined: result is the wrapped serial value (mod 2^N).
- range_err behaviour and timing are identical in both builds.

## Structure
- Package sign_restore_pkg contains:
  - state enum (IDLE, SHIFT, DONE);
  - state encoding width;
  - helper constants for the max/min signed values as functions of N.
- One sub-module, bit_serial_negator: a 1-bit cell holding seen_one, with inputs b, sign, clear and enable, and output out_bit. The top level holds the FSM, counter, shift/result registers, range check and saturation mux.

## Test plan
All cases use N=8.
- sign=1, mag=5 → out_valid exactly 8 cycles after accept; result=0xFB, range_err=0.
- sign=0, mag=127 → 0x7F, err 0; sign=1, mag=128 → 0x80, err 0; sign=1, mag=0 → 0x00, err 0.
- sign=0, mag=128 → range_err=1; result 0x7F with SATURATE_EN, 0x80 without.
- sign=1, mag=200 → range_err=1; result 0x80 with SATURATE_EN, 0x38 without.
- out_ready held low for 5 cycles in DONE → result and range_err stable, in_ready=0; in_valid pulsed meanwhile is ignored. Raising out_ready returns to IDLE, and the next accept works.
- rst_n low for one edge at SHIFT bit 3 → next cycle IDLE, in_ready=1, out_valid=0, result=0. A following operand (sign=1, mag=1) yields 0xFF.
